lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/mem_pkg.sv | 30 +++
 rtl/load_align.sv | 38 +++
 rtl/lsu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 access widths, FSM states
// and access-size helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        LD_FIRST,
        LD_LAST,
        ST_ACK,
        ERR
    } lsu_state_e;

    // Low two funct3 bits encode log2 of the access size in bytes.
    function automatic logic [3:0] access_bytes(input logic [1:0] size_code);
        return 4'd1 << size_code;
    endfunction

    function automatic logic crosses_word(input logic [2:0] byte_off, input logic [1:0] size_code);
        return ({1'b0, byte_off} + access_bytes(size_code)) > 4'd8;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed bytes out of one or two memory words
// (little-endian) and sign- or zero-extends them to the full data width.
module load_align
    import mem_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] lo_word_i,
    input  logic [N-1:0] hi_word_i,
    input  logic [2:0]   byte_off_i,
    input  logic [2:0]   width_i,
    output logic [N-1:0] data_o
);

    localparam int SW = $clog2(2 * N);

    logic [2*N-1:0] pair;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   raw;

    assign pair  = {hi_word_i, lo_word_i};
    assign shamt = SW'({byte_off_i, 3'b000});
    assign raw   = pair[shamt +: N];

    always_comb begin
        data_o = raw;
        case (width_i)
            F3_B:    data_o = {{(N-8){raw[7]}}, raw[7:0]};
            F3_H:    data_o = {{(N-16){raw[15]}}, raw[15:0]};
            F3_W:    data_o = {{(N-32){raw[31]}}, raw[31:0]};
            F3_BU:   data_o = {{(N-8){1'b0}}, raw[7:0]};
            F3_HU:   data_o = {{(N-16){1'b0}}, raw[15:0]};
            F3_WU:   data_o = {{(N-32){1'b0}}, raw[31:0]};
            default: data_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the pipeline and a word-wide synchronous data memory.
// Split loads take two reads; misaligned stores and out-of-range accesses fault.
//
// state    | meaning
// IDLE     | no access in flight
// LD_FIRST | split load: first word returning, second word being read
// LD_LAST  | load data returning, response this cycle
// ST_ACK   | store written, response this cycle
// ERR      | faulted access, error response this cycle
module lsu
    import mem_pkg::*;
#(
    parameter int N  = 64,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [N-1:0]  req_addr,
    input  logic [2:0]    req_width,
    input  logic [N-1:0]  req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [N-1:0]  resp_rdata,
    output logic [AW-1:0] dm_wordAddr,
    output logic          dm_readEnable,
    output logic          dm_writeEnable,
    output logic [2:0]    dm_memWidth,
    output logic [2:0]    dm_byteOffset,
    output logic [N-1:0]  dm_writeData,
    input  logic [N-1:0]  dm_readData
);

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] word_q;
    logic [2:0]    off_q;
    logic [2:0]    width_q;
    logic          split_q;
    logic [N-1:0]  lo_q;
    logic          resp_valid_q;
    logic          resp_err_q;

    logic [AW-1:0] req_word;
    logic          addr_fault;
    logic          split;
    logic          fault;
    logic          accept;
    logic [N-1:0]  aligned;

    assign req_word   = req_addr[AW+2:3];
    assign addr_fault = |req_addr[N-1:AW+3];
    assign split      = crosses_word(req_addr[2:0], req_width[1:0]);
    // A split load on the last word would need word 2^AW, which does not exist.
    assign fault      = addr_fault | (split & (req_write | (&req_word)));

    // Held low during reset so nothing is accepted while the unit is cleared.
    assign req_ready  = ~reset & (state_q != LD_FIRST);
    assign accept     = req_valid & req_ready;

    always_comb begin
        dm_wordAddr    = req_word;
        dm_memWidth    = req_width;
        dm_byteOffset  = req_addr[2:0];
        dm_writeData   = req_wdata;
        dm_readEnable  = accept & ~req_write & ~fault;
        dm_writeEnable = accept & req_write & ~fault;
        if (state_q == LD_FIRST) begin
            dm_wordAddr   = word_q + AW'(1);
            dm_memWidth   = width_q;
            dm_byteOffset = off_q;
            dm_readEnable = 1'b1;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (state_q == LD_FIRST) begin
            state_d = LD_LAST;
        end else if (accept) begin
            if (fault)          state_d = ERR;
            else if (req_write) state_d = ST_ACK;
            else if (split)     state_d = LD_FIRST;
            else                state_d = LD_LAST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            word_q       <= '0;
            off_q        <= '0;
            width_q      <= '0;
            split_q      <= 1'b0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_d == LD_LAST) || (state_d == ST_ACK) || (state_d == ERR);
            resp_err_q   <= (state_d == ERR);
            if (accept) begin
                word_q  <= req_word;
                off_q   <= req_addr[2:0];
                width_q <= req_width;
                split_q <= split;
            end
            if (state_q == LD_FIRST) begin
                lo_q <= dm_readData;
            end
        end
    end

    load_align #(.N(N)) u_align (
        .lo_word_i  (split_q ? lo_q : dm_readData),
        .hi_word_i  (dm_readData),
        .byte_off_i (off_q),
        .width_i    (width_q),
        .data_o     (aligned)
    );

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (state_q == LD_LAST) ? aligned : '0;

endmodule
